// File: rtl/retire_rob_pkg.sv
// Shared types and constants for the ROB retire controller.
// Pure declarations plus a small helper that forms one retire slot from a head entry.
// No state lives here.
package retire_rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int IDX_W     = $clog2(ROB_DEPTH);
  localparam int PREG_W    = 6;
  localparam int DATA_W    = 32;
  localparam int NUM_CMP   = 3;

  typedef struct packed {
    logic RegWrite;
    logic MemWrite;
  } controlStruct;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    logic [DATA_W-1:0] result;
    controlStruct      control;
  } robEntryStruct;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] robNum;
  } completeStruct;

  typedef struct packed {
    logic             valid1;
    logic             valid2;
    logic [IDX_W-1:0] robNum1;
    logic [IDX_W-1:0] robNum2;
  } robAllocStruct;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    logic [DATA_W-1:0] result;
    logic [31:0]       pc;
    logic              store;
    logic              free_valid;
  } retireStruct;

  // Ring-index addition; the natural IDX_W-bit wrap gives mod-ROB_DEPTH arithmetic.
  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] a, input logic [1:0] b);
    return a + IDX_W'(b);
  endfunction

  // One commit slot: payload copied from the entry when it retires, all-zero otherwise.
  // Physical register 0 is hard-wired and must never return to the free list.
  function automatic retireStruct make_retire(input robEntryStruct e, input logic fire);
    retireStruct r;
    r = '0;
    if (fire && e.valid) begin
      r.valid      = 1'b1;
      r.rd         = e.rd;
      r.rd_old     = e.rd_old;
      r.result     = e.result;
      r.pc         = e.pc;
      r.store      = e.control.MemWrite;
      r.free_valid = e.control.RegWrite && (e.rd_old != '0);
    end
    return r;
  endfunction

endpackage

// File: rtl/retire_rob_if.sv
// Bundle of dispatch, complete, ROB-table read and commit signals around the retire controller.
// master = surrounding pipeline (dispatch, complete stage, ROB table); slave = retire_rob.
// No timing of its own; alloc_ok is the only backpressure signal toward dispatch.
interface retire_rob_if;
  import retire_rob_pkg::*;

  logic                     alloc_req1;
  logic                     alloc_req2;
  logic                     alloc_ok;
  logic [IDX_W-1:0]         alloc_robNum1;
  logic [IDX_W-1:0]         alloc_robNum2;
  logic [NUM_CMP-1:0]       cmp_valid;
  logic [IDX_W-1:0]         cmp_robNum [NUM_CMP];
  logic [IDX_W-1:0]         head_idx0;
  logic [IDX_W-1:0]         head_idx1;
  robEntryStruct            head_entry0;
  robEntryStruct            head_entry1;
  logic                     ret_valid0, ret_valid1;
  logic [PREG_W-1:0]        ret_rd0, ret_rd1;
  logic [DATA_W-1:0]        ret_result0, ret_result1;
  logic [31:0]              ret_pc0, ret_pc1;
  logic                     ret_store0, ret_store1;
  logic                     free_valid0, free_valid1;
  logic [PREG_W-1:0]        free_preg0, free_preg1;
  logic [IDX_W:0]           rob_count;
  logic                     rob_empty;
  logic                     rob_full;

  modport master (
    output alloc_req1, alloc_req2, cmp_valid, cmp_robNum, head_entry0, head_entry1,
    input  alloc_ok, alloc_robNum1, alloc_robNum2, head_idx0, head_idx1,
    input  ret_valid0, ret_valid1, ret_rd0, ret_rd1, ret_result0, ret_result1,
    input  ret_pc0, ret_pc1, ret_store0, ret_store1,
    input  free_valid0, free_valid1, free_preg0, free_preg1,
    input  rob_count, rob_empty, rob_full
  );

  modport slave (
    input  alloc_req1, alloc_req2, cmp_valid, cmp_robNum, head_entry0, head_entry1,
    output alloc_ok, alloc_robNum1, alloc_robNum2, head_idx0, head_idx1,
    output ret_valid0, ret_valid1, ret_rd0, ret_rd1, ret_result0, ret_result1,
    output ret_pc0, ret_pc1, ret_store0, ret_store1,
    output free_valid0, free_valid1, free_preg0, free_preg1,
    output rob_count, rob_empty, rob_full
  );

endinterface

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy registers of the ROB ring and the allocation grant.
// Pointers update at the edge; alloc_ok is combinational from the registered count.
// Same-cycle retires are not credited to alloc_ok, so a full ROB refuses allocation until the next cycle.
module rob_ptr_ctrl
  import retire_rob_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alloc_need_i,
  input  logic [1:0]       ret_cnt_i,
  output logic             alloc_ok_o,
  output logic             alloc_fire_o,
  output logic [IDX_W-1:0] head_o,
  output logic [IDX_W-1:0] tail_o,
  output logic [IDX_W:0]   count_o
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(ROB_DEPTH);

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [1:0]       alloc_amt;

  // Grant check and next pointer values for this cycle's allocations and retires
  always_comb begin
    alloc_ok_o   = (DEPTH_C - count_q) >= (IDX_W+1)'(alloc_need_i);
    alloc_fire_o = alloc_ok_o && (alloc_need_i != 2'd0);
    alloc_amt    = alloc_ok_o ? alloc_need_i : 2'd0;
    head_d       = idx_add(head_q, ret_cnt_i);
    tail_d       = idx_add(tail_q, alloc_amt);
    count_d      = count_q + (IDX_W+1)'(alloc_amt) - (IDX_W+1)'(ret_cnt_i);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;

endmodule

// File: rtl/retire_rob.sv
// Retire controller: allocates ROB numbers, tracks done bits, commits up to two entries per cycle in order.
// Complete at edge E -> retire decision at edge E+1 -> ret_*/free_* registered, visible the cycle after.
// Dispatch is throttled by alloc_ok; at most one store commits per cycle, a second store waits a cycle.
module retire_rob
  import retire_rob_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  retire_rob_if.slave  rob_if
);

  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic [1:0]           alloc_need;
  logic [1:0]           ret_cnt;
  logic                 alloc_ok;
  logic                 alloc_fire;
  logic [IDX_W-1:0]     head, head1, tail;
  logic [IDX_W:0]       count;
  robAllocStruct        alloc;
  completeStruct        cmp [NUM_CMP];
  logic [NUM_CMP-1:0]   cmp_in_range;
  robEntryStruct        entry0, entry1;
  logic                 r0, r1;
  retireStruct          ret0_d, ret1_d, ret0_q, ret1_q;

  // A lone req2 is illegal and treated as no request
  always_comb begin
    alloc_need = 2'd0;
    if (rob_if.alloc_req1) alloc_need = rob_if.alloc_req2 ? 2'd2 : 2'd1;
  end

  rob_ptr_ctrl u_ptr (
    .clk          (clk),
    .reset        (reset),
    .alloc_need_i (alloc_need),
    .ret_cnt_i    (ret_cnt),
    .alloc_ok_o   (alloc_ok),
    .alloc_fire_o (alloc_fire),
    .head_o       (head),
    .tail_o       (tail),
    .count_o      (count)
  );

  // Slots granted to dispatch this cycle
  always_comb begin
    head1         = idx_add(head, 2'd1);
    alloc.valid1  = alloc_fire;
    alloc.valid2  = alloc_fire && (alloc_need == 2'd2);
    alloc.robNum1 = tail;
    alloc.robNum2 = idx_add(tail, 2'd1);
  end

  // Complete ports; only slots inside the occupied window [head, head+count) may be marked done
  always_comb begin
    logic [IDX_W-1:0] off;
    off = '0;
    for (int k = 0; k < NUM_CMP; k++) begin
      cmp[k].valid    = rob_if.cmp_valid[k];
      cmp[k].robNum   = rob_if.cmp_robNum[k];
      off             = rob_if.cmp_robNum[k] - head;
      cmp_in_range[k] = {1'b0, off} < count;
    end
  end

  // In-order retire selection from registered state; a second store is held back a cycle
  always_comb begin
    entry0  = rob_if.head_entry0;
    entry1  = rob_if.head_entry1;
    r0      = (count != '0) && done_q[head] && entry0.valid;
    r1      = r0 && (count > (IDX_W+1)'(1)) && done_q[head1] && entry1.valid
              && !(entry0.control.MemWrite && entry1.control.MemWrite);
    ret_cnt = {1'b0, r0} + {1'b0, r1};
    ret0_d  = make_retire(entry0, r0);
    ret1_d  = make_retire(entry1, r1);
  end

  // Done bitmap: set by completions, cleared on retire, and cleared on allocation (allocation wins)
  always_comb begin
    done_d = done_q;
    for (int k = 0; k < NUM_CMP; k++) begin
      if (cmp[k].valid && cmp_in_range[k]) done_d[cmp[k].robNum] = 1'b1;
    end
    if (r0) done_d[head]  = 1'b0;
    if (r1) done_d[head1] = 1'b0;
    if (alloc.valid1) done_d[alloc.robNum1] = 1'b0;
    if (alloc.valid2) done_d[alloc.robNum2] = 1'b0;
  end

  // Done bits and registered commit outputs; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= '0;
      ret0_q <= '0;
      ret1_q <= '0;
    end else begin
      done_q <= done_d;
      ret0_q <= ret0_d;
      ret1_q <= ret1_d;
    end
  end

  assign rob_if.alloc_ok      = alloc_ok;
  assign rob_if.alloc_robNum1 = alloc.robNum1;
  assign rob_if.alloc_robNum2 = alloc.robNum2;
  assign rob_if.head_idx0     = head;
  assign rob_if.head_idx1     = head1;
  assign rob_if.ret_valid0    = ret0_q.valid;
  assign rob_if.ret_valid1    = ret1_q.valid;
  assign rob_if.ret_rd0       = ret0_q.rd;
  assign rob_if.ret_rd1       = ret1_q.rd;
  assign rob_if.ret_result0   = ret0_q.result;
  assign rob_if.ret_result1   = ret1_q.result;
  assign rob_if.ret_pc0       = ret0_q.pc;
  assign rob_if.ret_pc1       = ret1_q.pc;
  assign rob_if.ret_store0    = ret0_q.store;
  assign rob_if.ret_store1    = ret1_q.store;
  assign rob_if.free_valid0   = ret0_q.free_valid;
  assign rob_if.free_valid1   = ret1_q.free_valid;
  assign rob_if.free_preg0    = ret0_q.free_valid ? ret0_q.rd_old : '0;
  assign rob_if.free_preg1    = ret1_q.free_valid ? ret1_q.rd_old : '0;
  assign rob_if.rob_count     = count;
  assign rob_if.rob_empty     = (count == '0);
  assign rob_if.rob_full      = (count == (IDX_W+1)'(ROB_DEPTH));

  // Dispatch must not request the second slot alone
  a_req2_alone: assert property (@(posedge clk) disable iff (reset)
    !(rob_if.alloc_req2 && !rob_if.alloc_req1));

  // Completions must target an occupied slot
  a_cmp_range: assert property (@(posedge clk) disable iff (reset)
    ((rob_if.cmp_valid & ~cmp_in_range) == '0));

endmodule

// File: tb/tb_retire_rob.sv
// Directed bench for retire_rob: the bench models the ROB entry table and checks hand-computed results.
module tb_retire_rob;
  import retire_rob_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  robEntryStruct tbl [ROB_DEPTH];

  retire_rob_if rif ();

  retire_rob dut (
    .clk    (clk),
    .reset  (reset),
    .rob_if (rif)
  );

  always #5 clk = ~clk;

  assign rif.head_entry0 = tbl[rif.head_idx0];
  assign rif.head_entry1 = tbl[rif.head_idx1];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rif.alloc_req1 = 1'b0;
    rif.alloc_req2 = 1'b0;
    rif.cmp_valid  = '0;
    for (int k = 0; k < NUM_CMP; k++) rif.cmp_robNum[k] = '0;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_entry(input int idx, input logic [31:0] pc, input logic [PREG_W-1:0] rd,
                           input logic [PREG_W-1:0] rd_old, input logic [DATA_W-1:0] res,
                           input logic regw, input logic memw);
    tbl[idx].valid            = 1'b1;
    tbl[idx].pc               = pc;
    tbl[idx].rd               = rd;
    tbl[idx].rd_old           = rd_old;
    tbl[idx].result           = res;
    tbl[idx].control.RegWrite = regw;
    tbl[idx].control.MemWrite = memw;
  endtask

  task automatic complete(input int n, input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b,
                          input logic [IDX_W-1:0] c);
    rif.cmp_robNum[0] = a;
    rif.cmp_robNum[1] = b;
    rif.cmp_robNum[2] = c;
    rif.cmp_valid     = (n >= 3) ? 3'b111 : (n == 2) ? 3'b011 : (n == 1) ? 3'b001 : 3'b000;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (rif.rob_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", rif.rob_empty); end
    checks++; if (rif.alloc_ok !== 1'b1) begin errors++; $display("FAIL reset_alloc_ok: got %b want 1", rif.alloc_ok); end
    checks++; if (rif.rob_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", rif.rob_count); end
    checks++; if (rif.ret_valid0 !== 1'b0 || rif.ret_valid1 !== 1'b0) begin errors++; $display("FAIL reset_ret_valid: got %b%b want 00", rif.ret_valid0, rif.ret_valid1); end
    checks++; if (rif.free_valid0 !== 1'b0 || rif.free_valid1 !== 1'b0) begin errors++; $display("FAIL reset_free_valid: got %b%b want 00", rif.free_valid0, rif.free_valid1); end
    checks++; if (rif.head_idx0 !== 4'd0 || rif.alloc_robNum1 !== 4'd0) begin errors++; $display("FAIL reset_ptrs: head %0d tail %0d want 0 0", rif.head_idx0, rif.alloc_robNum1); end
  endtask

  task automatic test_alloc_fill();
    for (int i = 0; i < 8; i++) begin
      rif.alloc_req1 = 1'b1;
      rif.alloc_req2 = 1'b1;
      #1;
      checks++;
      if (rif.alloc_ok !== 1'b1 || rif.alloc_robNum1 !== 4'(2*i) || rif.alloc_robNum2 !== 4'(2*i+1)) begin
        errors++;
        $display("FAIL alloc_fill_%0d: ok %b nums %0d,%0d want 1 %0d,%0d", i, rif.alloc_ok, rif.alloc_robNum1, rif.alloc_robNum2, 2*i, 2*i+1);
      end
      tick();
    end
    #1;
    checks++; if (rif.rob_full !== 1'b1 || rif.rob_count !== 5'd16) begin errors++; $display("FAIL fill_full: full %b count %0d want 1 16", rif.rob_full, rif.rob_count); end
    checks++; if (rif.alloc_ok !== 1'b0) begin errors++; $display("FAIL fill_9th_req: alloc_ok %b want 0", rif.alloc_ok); end
    rif.alloc_req2 = 1'b0;
    #1;
    checks++; if (rif.alloc_ok !== 1'b0) begin errors++; $display("FAIL fill_single_req: alloc_ok %b want 0", rif.alloc_ok); end
    idle();
  endtask

  task automatic test_in_order();
    apply_reset();
    set_entry(0, 32'h100, 6'd5, 6'd10, 32'hAAAA, 1'b1, 1'b0);
    set_entry(1, 32'h104, 6'd6, 6'd11, 32'hBBBB, 1'b1, 1'b0);
    rif.alloc_req1 = 1'b1; rif.alloc_req2 = 1'b1;
    tick();
    idle();
    complete(1, 4'd1, 4'd0, 4'd0);
    tick();
    idle();
    tick();
    checks++; if (rif.ret_valid0 !== 1'b0 || rif.ret_valid1 !== 1'b0) begin errors++; $display("FAIL inorder_hold: ret_valid %b%b want 00", rif.ret_valid0, rif.ret_valid1); end
    checks++; if (rif.rob_count !== 5'd2) begin errors++; $display("FAIL inorder_count: got %0d want 2", rif.rob_count); end
    complete(1, 4'd0, 4'd0, 4'd0);
    tick();
    idle();
    checks++; if (rif.ret_valid0 !== 1'b0) begin errors++; $display("FAIL inorder_latency: ret_valid0 %b want 0", rif.ret_valid0); end
    tick();
    checks++; if (rif.ret_valid0 !== 1'b1 || rif.ret_valid1 !== 1'b1) begin errors++; $display("FAIL inorder_pair: ret_valid %b%b want 11", rif.ret_valid0, rif.ret_valid1); end
    checks++; if (rif.ret_pc0 !== 32'h100 || rif.ret_pc1 !== 32'h104) begin errors++; $display("FAIL inorder_pc: got %h %h want 100 104", rif.ret_pc0, rif.ret_pc1); end
    checks++; if (rif.ret_rd0 !== 6'd5 || rif.ret_result1 !== 32'hBBBB) begin errors++; $display("FAIL inorder_payload: rd0 %0d res1 %h want 5 bbbb", rif.ret_rd0, rif.ret_result1); end
    checks++; if (rif.free_valid0 !== 1'b1 || rif.free_preg0 !== 6'd10 || rif.free_preg1 !== 6'd11) begin errors++; $display("FAIL inorder_free: v0 %b p0 %0d p1 %0d want 1 10 11", rif.free_valid0, rif.free_preg0, rif.free_preg1); end
    checks++; if (rif.rob_count !== 5'd0) begin errors++; $display("FAIL inorder_drained: count %0d want 0", rif.rob_count); end
    tick();
    checks++; if (rif.ret_valid0 !== 1'b0 || rif.ret_pc0 !== 32'h0) begin errors++; $display("FAIL inorder_idle: v0 %b pc0 %h want 0 0", rif.ret_valid0, rif.ret_pc0); end
  endtask

  task automatic test_store_limit();
    set_entry(2, 32'h200, 6'd0, 6'd0, 32'h22, 1'b0, 1'b1);
    set_entry(3, 32'h204, 6'd0, 6'd0, 32'h33, 1'b0, 1'b1);
    rif.alloc_req1 = 1'b1; rif.alloc_req2 = 1'b1;
    tick();
    idle();
    complete(2, 4'd2, 4'd3, 4'd0);
    tick();
    idle();
    tick();
    checks++; if (rif.ret_valid0 !== 1'b1 || rif.ret_store0 !== 1'b1 || rif.ret_pc0 !== 32'h200) begin errors++; $display("FAIL store_first: v %b st %b pc %h want 1 1 200", rif.ret_valid0, rif.ret_store0, rif.ret_pc0); end
    checks++; if (rif.ret_valid1 !== 1'b0 || rif.ret_pc1 !== 32'h0 || rif.ret_store1 !== 1'b0) begin errors++; $display("FAIL store_second_held: v1 %b pc1 %h st1 %b want 0 0 0", rif.ret_valid1, rif.ret_pc1, rif.ret_store1); end
    checks++; if (rif.free_valid0 !== 1'b0) begin errors++; $display("FAIL store_no_free: free_valid0 %b want 0", rif.free_valid0); end
    tick();
    checks++; if (rif.ret_valid0 !== 1'b1 || rif.ret_pc0 !== 32'h204 || rif.ret_valid1 !== 1'b0) begin errors++; $display("FAIL store_next: v0 %b pc0 %h v1 %b want 1 204 0", rif.ret_valid0, rif.ret_pc0, rif.ret_valid1); end
    checks++; if (rif.rob_empty !== 1'b1) begin errors++; $display("FAIL store_empty: got %b want 1", rif.rob_empty); end
    tick();
  endtask

  task automatic test_wrap();
    int n;
    apply_reset();
    for (int i = 0; i < 15; i++) set_entry(i, 32'h1000 + 32'(4*i), 6'd1, 6'd0, 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rif.alloc_req1 = 1'b1;
      rif.alloc_req2 = (i < 7);
      tick();
    end
    idle();
    for (int c = 0; c < 5; c++) begin
      complete(3, 4'(3*c), 4'(3*c+1), 4'(3*c+2));
      tick();
    end
    idle();
    n = 0;
    while (n < 40 && rif.rob_empty !== 1'b1) begin
      tick();
      n++;
    end
    checks++; if (rif.rob_empty !== 1'b1) begin errors++; $display("FAIL wrap_drain_timeout: count %0d want 0", rif.rob_count); end
    checks++; if (rif.head_idx0 !== 4'd15 || rif.alloc_robNum1 !== 4'd15 || rif.alloc_robNum2 !== 4'd0) begin errors++; $display("FAIL wrap_ptrs: head %0d tail %0d next %0d want 15 15 0", rif.head_idx0, rif.alloc_robNum1, rif.alloc_robNum2); end
    set_entry(15, 32'h3C0, 6'd9, 6'd7, 32'h15, 1'b1, 1'b0);
    set_entry(0,  32'h400, 6'd3, 6'd0, 32'h16, 1'b1, 1'b0);
    rif.alloc_req1 = 1'b1; rif.alloc_req2 = 1'b1;
    tick();
    idle();
    complete(2, 4'd15, 4'd0, 4'd0);
    tick();
    idle();
    tick();
    checks++; if (rif.ret_valid0 !== 1'b1 || rif.ret_valid1 !== 1'b1 || rif.ret_pc0 !== 32'h3C0 || rif.ret_pc1 !== 32'h400) begin errors++; $display("FAIL wrap_retire: v %b%b pc %h %h want 11 3c0 400", rif.ret_valid0, rif.ret_valid1, rif.ret_pc0, rif.ret_pc1); end
    checks++; if (rif.free_valid0 !== 1'b1 || rif.free_preg0 !== 6'd7) begin errors++; $display("FAIL wrap_free0: v %b p %0d want 1 7", rif.free_valid0, rif.free_preg0); end
    checks++; if (rif.free_valid1 !== 1'b0 || rif.ret_rd1 !== 6'd3) begin errors++; $display("FAIL wrap_p0_not_freed: v1 %b rd1 %0d want 0 3", rif.free_valid1, rif.ret_rd1); end
    checks++; if (rif.head_idx0 !== 4'd1 || rif.rob_empty !== 1'b1) begin errors++; $display("FAIL wrap_head: head %0d empty %b want 1 1", rif.head_idx0, rif.rob_empty); end
  endtask

  task automatic test_full_back_to_back();
    for (int i = 0; i < 16; i++) set_entry(i, 32'h2000 + 32'(4*i), 6'd2, 6'd0, 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rif.alloc_req1 = 1'b1; rif.alloc_req2 = 1'b1;
      tick();
    end
    idle();
    #1;
    checks++; if (rif.rob_full !== 1'b1 || rif.rob_count !== 5'd16) begin errors++; $display("FAIL full_fill: full %b count %0d want 1 16", rif.rob_full, rif.rob_count); end
    complete(2, 4'd1, 4'd2, 4'd0);
    tick();
    idle();
    rif.alloc_req1 = 1'b1; rif.alloc_req2 = 1'b1;
    #1;
    checks++; if (rif.alloc_ok !== 1'b0) begin errors++; $display("FAIL full_no_credit: alloc_ok %b want 0", rif.alloc_ok); end
    tick();
    checks++; if (rif.rob_count !== 5'd14 || rif.alloc_ok !== 1'b1) begin errors++; $display("FAIL full_after_retire: count %0d ok %b want 14 1", rif.rob_count, rif.alloc_ok); end
    checks++; if (rif.ret_valid0 !== 1'b1 || rif.ret_valid1 !== 1'b1 || rif.ret_pc0 !== 32'h2004) begin errors++; $display("FAIL full_retire: v %b%b pc0 %h want 11 2004", rif.ret_valid0, rif.ret_valid1, rif.ret_pc0); end
    tick();
    idle();
    checks++; if (rif.rob_count !== 5'd16 || rif.rob_full !== 1'b1) begin errors++; $display("FAIL full_refill: count %0d full %b want 16 1", rif.rob_count, rif.rob_full); end
  endtask

  task automatic test_reset_mid();
    complete(3, 4'd3, 4'd4, 4'd5);
    tick();
    idle();
    reset = 1'b1;
    tick();
    checks++; if (rif.ret_valid0 !== 1'b0 || rif.ret_valid1 !== 1'b0) begin errors++; $display("FAIL rstmid_no_retire: v %b%b want 00", rif.ret_valid0, rif.ret_valid1); end
    checks++; if (rif.rob_count !== 5'd0 || rif.rob_empty !== 1'b1) begin errors++; $display("FAIL rstmid_count: count %0d empty %b want 0 1", rif.rob_count, rif.rob_empty); end
    checks++; if (rif.head_idx0 !== 4'd0 || rif.alloc_robNum1 !== 4'd0) begin errors++; $display("FAIL rstmid_ptrs: head %0d tail %0d want 0 0", rif.head_idx0, rif.alloc_robNum1); end
    reset = 1'b0;
    tick();
    checks++; if (rif.ret_valid0 !== 1'b0 || rif.free_valid0 !== 1'b0 || rif.rob_count !== 5'd0) begin errors++; $display("FAIL rstmid_after: v0 %b fv0 %b count %0d want 0 0 0", rif.ret_valid0, rif.free_valid0, rif.rob_count); end
  endtask

  initial begin
    for (int i = 0; i < ROB_DEPTH; i++) tbl[i] = '0;
    reset = 1'b1;
    idle();
    test_reset();
    test_alloc_fill();
    test_in_order();
    test_store_limit();
    test_wrap();
    test_full_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
